// File: rtl/axi_ocp_wr_bridge.sv
// AXI3 write channel (AW/W/B) to OCP write bridge: one OCP command per AW, beats streamed, responses returned on B.
// Optional build macro AXI_OCP_WLAST_CHECK_EN enables the sticky wlast mismatch flag (wlast_err).
module axi_ocp_wr_bridge #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic [2:0]        MCmd,
  output logic [ADDR_W-1:0] MAddr,
  output logic [ID_W-1:0]   MTagID,
  output logic [LEN_W:0]    MBurstLength,
  input  logic              SCmdAccept,
  output logic [DATA_W-1:0] MData,
  output logic              MDataValid,
  output logic              MDataLast,
  input  logic              SDataAccept,
  input  logic [1:0]        SResp,
  input  logic [ID_W-1:0]   STagID,
  output logic              MRespAccept,
  output logic              wlast_err
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned BL_W  = LEN_W + 1;

  localparam logic [2:0] MCMD_IDLE  = 3'b000;
  localparam logic [2:0] MCMD_WR    = 3'b001;
  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] BRESP_OKAY = 2'b00;
  localparam logic [1:0] BRESP_SLV  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } aw_t;

  state_t            state, state_nxt;
  aw_t               aw_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [OUT_W-1:0]  outst;
  logic              aw_hs, cmd_acc, w_hs, b_hs, r_acc, beat_last;

  assign beat_last = (beat_cnt == aw_q.len);
  assign aw_hs     = awvalid && awready;
  assign cmd_acc   = (state == S_CMD) && SCmdAccept;
  assign w_hs      = (state == S_DATA) && wvalid && SDataAccept;
  assign b_hs      = bvalid && bready;
  assign r_acc     = MRespAccept && (SResp != SRESP_NULL);

  assign MAddr  = aw_q.addr;
  assign MTagID = aw_q.id;

  // Response side may only take a new OCP response when the B slot is free or draining.
  assign MRespAccept = !rst && (!bvalid || bready);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational command/data pass-through outputs.
  always_comb begin
    state_nxt  = state;
    awready    = 1'b0;
    wready     = 1'b0;
    MCmd       = MCMD_IDLE;
    MDataValid = 1'b0;
    MDataLast  = 1'b0;
    MData      = '0;
    case (state)
      S_IDLE: begin
        awready = !rst && (outst < OUT_W'(MAX_OUTST));
        if (awvalid && awready) state_nxt = S_CMD;
      end
      S_CMD: begin
        MCmd = MCMD_WR;
        if (SCmdAccept) state_nxt = S_DATA;
      end
      S_DATA: begin
        MDataValid = wvalid;
        MData      = wdata;
        wready     = SDataAccept;
        MDataLast  = beat_last;
        if (wvalid && SDataAccept && beat_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Captured AW fields; held until the next AW handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_q         <= '0;
      MBurstLength <= '0;
    end else if (aw_hs) begin
      aw_q.id      <= awid;
      aw_q.addr    <= awaddr;
      aw_q.len     <= awlen;
      MBurstLength <= BL_W'(awlen) + BL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          beat_cnt <= '0;
    else if (cmd_acc) beat_cnt <= '0;
    else if (w_hs)    beat_cnt <= beat_cnt + LEN_W'(1);
  end

  // Outstanding count; a B for an untracked response must not wrap the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst <= '0;
    end else begin
      case ({cmd_acc, b_hs && (outst != '0)})
        2'b10:   outst <= outst + OUT_W'(1);
        2'b01:   outst <= outst - OUT_W'(1);
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0;
      bid    <= '0;
      bresp  <= BRESP_OKAY;
    end else if (r_acc) begin
      bvalid <= 1'b1;
      bid    <= STagID;
      bresp  <= (SResp == SRESP_DVA) ? BRESP_OKAY : BRESP_SLV;
    end else if (b_hs) begin
      bvalid <= 1'b0;
    end
  end

`ifdef AXI_OCP_WLAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                             wlast_err <= 1'b0;
    else if (w_hs && (wlast != beat_last)) wlast_err <= 1'b1;
  end
`else
  logic unused_wlast;
  assign unused_wlast = wlast;
  assign wlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_ocp_wr_bridge.sv
// Directed bench for axi_ocp_wr_bridge: reset, single beat, stalled burst, flow control, error map, wlast/reset.
module tb_axi_ocp_wr_bridge;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;
`ifdef AXI_OCP_WLAST_CHECK_EN
  localparam logic EXP_WLERR = 1'b1;
`else
  localparam logic EXP_WLERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic              awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic              wlast, wvalid, wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [2:0]        MCmd;
  logic [ADDR_W-1:0] MAddr;
  logic [ID_W-1:0]   MTagID;
  logic [LEN_W:0]    MBurstLength;
  logic              SCmdAccept;
  logic [DATA_W-1:0] MData;
  logic              MDataValid, MDataLast, SDataAccept;
  logic [1:0]        SResp;
  logic [ID_W-1:0]   STagID;
  logic              MRespAccept, wlast_err;

  int n_tests = 0;
  int n_fail  = 0;

  axi_ocp_wr_bridge #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUTST(4)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .MCmd(MCmd), .MAddr(MAddr), .MTagID(MTagID), .MBurstLength(MBurstLength), .SCmdAccept(SCmdAccept),
    .MData(MData), .MDataValid(MDataValid), .MDataLast(MDataLast), .SDataAccept(SDataAccept),
    .SResp(SResp), .STagID(STagID), .MRespAccept(MRespAccept), .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full burst with immediate command/data acceptance; waits (bounded) for awready.
  task automatic send_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    int n = 0;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    #1;
    while (!awready && n < 50) begin tick(); n++; #1; end
    n_tests++;
    if (n >= 50) begin n_fail++; $display("FAIL send_burst_awready_timeout id=%0d got awready=%b exp=1", id, awready); end
    tick();
    awvalid = 1'b0; SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = 32'(i); wlast = (i == int'(len)); SDataAccept = 1'b1;
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0; SDataAccept = 1'b0;
  endtask

  // Returns n DVA responses with tags first..first+n-1 and checks each B.
  task automatic drain(input int n, input int first);
    for (int k = 0; k < n; k++) begin
      SResp = 2'b01; STagID = ID_W'(first + k);
      tick();
      SResp = 2'b00; bready = 1'b1;
      #1;
      n_tests++;
      if ({bvalid, bid, bresp} !== {1'b1, ID_W'(first + k), 2'b00}) begin
        n_fail++; $display("FAIL drain_b%0d got v/id/resp=%b/%0d/%b exp=1/%0d/00", k, bvalid, bid, bresp, first + k);
      end
      tick();
      bready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({awready, wready, MCmd, MDataValid, MDataLast, bvalid, MRespAccept, wlast_err} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl got ar/wr/cmd/dv/dl/bv/ra/we=%b/%b/%b/%b/%b/%b/%b/%b exp all 0",
                         awready, wready, MCmd, MDataValid, MDataLast, bvalid, MRespAccept, wlast_err);
    end
    n_tests++;
    if ({bid, bresp, MAddr, MTagID, MBurstLength, MData} !== '0) begin
      n_fail++; $display("FAIL reset_fields got bid=%0h bresp=%b addr=%0h tag=%0h bl=%0d data=%0h exp 0",
                         bid, bresp, MAddr, MTagID, MBurstLength, MData);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({awready, MRespAccept} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release got awready=%b MRespAccept=%b exp 1/1", awready, MRespAccept);
    end
  endtask

  task automatic test_single_beat;
    awvalid = 1'b1; awid = 4'd3; awaddr = 32'h100; awlen = 4'd0;
    #1;
    n_tests++;
    if ({awready, MCmd} !== {1'b1, 3'b000}) begin
      n_fail++; $display("FAIL single_aw got awready=%b MCmd=%b exp 1/000", awready, MCmd);
    end
    tick();
    awvalid = 1'b0;
    #1;
    n_tests++;
    if ({MCmd, MAddr, MTagID, MBurstLength, awready} !== {3'b001, 32'h100, 4'd3, 5'd1, 1'b0}) begin
      n_fail++; $display("FAIL single_cmd got cmd=%b addr=%0h tag=%0d bl=%0d ar=%b exp 001/100/3/1/0",
                         MCmd, MAddr, MTagID, MBurstLength, awready);
    end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    wvalid = 1'b1; wdata = 32'h55; wlast = 1'b1; SDataAccept = 1'b1;
    #1;
    n_tests++;
    if ({MCmd, MDataValid, MData, MDataLast, wready} !== {3'b000, 1'b1, 32'h55, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL single_data got cmd=%b dv=%b data=%0h dl=%b wr=%b exp 000/1/55/1/1",
                         MCmd, MDataValid, MData, MDataLast, wready);
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0; SDataAccept = 1'b0;
    SResp = 2'b01; STagID = 4'd3;
    #1;
    n_tests++;
    if ({MDataValid, awready, MRespAccept} !== 3'b011) begin
      n_fail++; $display("FAIL single_idle got dv=%b ar=%b ra=%b exp 0/1/1", MDataValid, awready, MRespAccept);
    end
    tick();
    SResp = 2'b00;
    #1;
    n_tests++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd3, 2'b00}) begin
      n_fail++; $display("FAIL single_b got v/id/resp=%b/%0d/%b exp 1/3/00", bvalid, bid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #1;
    n_tests++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL single_b_done got bvalid=%b exp 0", bvalid); end
  endtask

  task automatic test_burst_stall;
    logic [5:0] pat = 6'b110011;
    int b = 0;
    awvalid = 1'b1; awid = 4'd1; awaddr = 32'h200; awlen = 4'd3;
    tick();
    awvalid = 1'b0;
    #1;
    n_tests++;
    if (MBurstLength !== 5'd4) begin n_fail++; $display("FAIL burst_len got=%0d exp=4", MBurstLength); end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wvalid = 1'b1; wdata = 32'(32'hA0 + b); wlast = (b == 3); SDataAccept = pat[c];
      #1;
      n_tests++;
      if ({wready, MDataValid, MData, MDataLast} !== {pat[c], 1'b1, 32'(32'hA0 + b), (b == 3)}) begin
        n_fail++; $display("FAIL burst_cyc%0d got wr=%b dv=%b data=%0h dl=%b exp %b/1/%0h/%b",
                           c, wready, MDataValid, MData, MDataLast, pat[c], 32'hA0 + b, (b == 3));
      end
      tick();
      if (pat[c]) b++;
    end
    wvalid = 1'b0; wlast = 1'b0; SDataAccept = 1'b0;
    #1;
    n_tests++;
    if ({MDataValid, awready} !== 2'b01) begin
      n_fail++; $display("FAIL burst_end got dv=%b ar=%b exp 0/1", MDataValid, awready);
    end
    drain(1, 1);
  endtask

  task automatic test_flow_control;
    for (int i = 0; i < 4; i++) send_burst(ID_W'(i), 32'h1000 + 32'(i * 16), 4'd0);
    awvalid = 1'b1; awid = 4'd9; awaddr = 32'h2000; awlen = 4'd0;
    #1;
    n_tests++;
    if (awready !== 1'b0) begin n_fail++; $display("FAIL flow_full got awready=%b exp 0", awready); end
    SResp = 2'b01; STagID = 4'd0;
    tick();
    SResp = 2'b00; bready = 1'b1;
    #1;
    n_tests++;
    if ({awready, bvalid} !== 2'b01) begin
      n_fail++; $display("FAIL flow_bpend got awready=%b bvalid=%b exp 0/1", awready, bvalid);
    end
    tick();
    bready = 1'b0;
    #1;
    n_tests++;
    if (awready !== 1'b1) begin n_fail++; $display("FAIL flow_freed got awready=%b exp 1", awready); end
    tick();
    awvalid = 1'b0;
    #1;
    n_tests++;
    if ({MCmd, MTagID, MAddr} !== {3'b001, 4'd9, 32'h2000}) begin
      n_fail++; $display("FAIL flow_fifth got cmd=%b tag=%0d addr=%0h exp 001/9/2000", MCmd, MTagID, MAddr);
    end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0; wvalid = 1'b1; wlast = 1'b1; SDataAccept = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; SDataAccept = 1'b0;
    drain(4, 1);
  endtask

  task automatic test_err_map;
    SResp = 2'b11; STagID = 4'd5;
    tick();
    SResp = 2'b01; STagID = 4'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({bvalid, bid, bresp, MRespAccept} !== {1'b1, 4'd5, 2'b10, 1'b0}) begin
        n_fail++; $display("FAIL err_hold%0d got v/id/resp/ra=%b/%0d/%b/%b exp 1/5/10/0", c, bvalid, bid, bresp, MRespAccept);
      end
      tick();
    end
    bready = 1'b1;
    #1;
    n_tests++;
    if (MRespAccept !== 1'b1) begin n_fail++; $display("FAIL err_accept got MRespAccept=%b exp 1", MRespAccept); end
    tick();
    SResp = 2'b00;
    #1;
    n_tests++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd7, 2'b00}) begin
      n_fail++; $display("FAIL err_next got v/id/resp=%b/%0d/%b exp 1/7/00", bvalid, bid, bresp);
    end
    tick();
    bready = 1'b0;
    #1;
    n_tests++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL err_done got bvalid=%b exp 0", bvalid); end
  endtask

  task automatic test_simultaneous;
    send_burst(4'd0, 32'h300, 4'd0);
    send_burst(4'd1, 32'h310, 4'd0);
    SResp = 2'b01; STagID = 4'd0;
    tick();
    SResp = 2'b00;
    awvalid = 1'b1; awid = 4'd2; awaddr = 32'h320; awlen = 4'd0;
    tick();
    awvalid = 1'b0; SCmdAccept = 1'b1; bready = 1'b1;
    #1;
    n_tests++;
    if ({MCmd, bvalid} !== {3'b001, 1'b1}) begin
      n_fail++; $display("FAIL simul_setup got MCmd=%b bvalid=%b exp 001/1", MCmd, bvalid);
    end
    tick();
    SCmdAccept = 1'b0; bready = 1'b0;
    wvalid = 1'b1; wlast = 1'b1; SDataAccept = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; SDataAccept = 1'b0;
    send_burst(4'd3, 32'h330, 4'd0);
    send_burst(4'd4, 32'h340, 4'd0);
    awvalid = 1'b1;
    #1;
    n_tests++;
    if (awready !== 1'b0) begin n_fail++; $display("FAIL simul_outst got awready=%b exp 0 (outst 4)", awready); end
    awvalid = 1'b0;
    drain(4, 1);
  endtask

  task automatic test_wlast_and_reset;
    awvalid = 1'b1; awid = 4'd6; awaddr = 32'h400; awlen = 4'd1;
    tick();
    awvalid = 1'b0; SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    wvalid = 1'b1; wdata = 32'hB0; wlast = 1'b1; SDataAccept = 1'b1;
    #1;
    n_tests++;
    if (MDataLast !== 1'b0) begin n_fail++; $display("FAIL wlast_beat0 got MDataLast=%b exp 0", MDataLast); end
    tick();
    wdata = 32'hB1; wlast = 1'b1;
    #1;
    n_tests++;
    if ({wlast_err, MDataValid, MDataLast, MData} !== {EXP_WLERR, 1'b1, 1'b1, 32'hB1}) begin
      n_fail++; $display("FAIL wlast_beat1 got we=%b dv=%b dl=%b data=%0h exp %b/1/1/b1", wlast_err, MDataValid, MDataLast, MData, EXP_WLERR);
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0; SDataAccept = 1'b0;
    tick();
    n_tests++;
    if ({wlast_err, MDataValid} !== {EXP_WLERR, 1'b0}) begin
      n_fail++; $display("FAIL wlast_sticky got we=%b dv=%b exp %b/0", wlast_err, MDataValid, EXP_WLERR);
    end
    drain(1, 6);
    awvalid = 1'b1; awid = 4'd8; awaddr = 32'h500; awlen = 4'd3;
    tick();
    awvalid = 1'b0; SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0; wvalid = 1'b1; wdata = 32'hC0; SDataAccept = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({awready, wready, MCmd, MDataValid, MDataLast, bvalid, MRespAccept, wlast_err} !== 10'b0 ||
        {MAddr, MTagID, MBurstLength, MData, bid, bresp} !== '0) begin
      n_fail++; $display("FAIL midreset got ar/wr/cmd/dv/dl/bv/ra/we=%b/%b/%b/%b/%b/%b/%b/%b addr=%0h tag=%0d bl=%0d data=%0h exp all 0",
                         awready, wready, MCmd, MDataValid, MDataLast, bvalid, MRespAccept, wlast_err, MAddr, MTagID, MBurstLength, MData);
    end
    rst = 1'b0; wvalid = 1'b0; SDataAccept = 1'b0;
    tick(); tick();
    n_tests++;
    if ({bvalid, awready, MCmd} !== {1'b0, 1'b1, 3'b000}) begin
      n_fail++; $display("FAIL postreset got bvalid=%b awready=%b MCmd=%b exp 0/1/000", bvalid, awready, MCmd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    SCmdAccept = 1'b0; SDataAccept = 1'b0; SResp = 2'b00; STagID = '0;
    test_reset();
    test_single_beat();
    test_burst_stall();
    test_flow_control();
    test_err_map();
    test_simultaneous();
    test_wlast_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
